dfe_tone_injector: RTL and testbench

- Two-tone digital stimulus source for the DFE notch-filter chain. Streams on a valid/ready interface into the dual-notch filter input.
- Synthesises the sum of two sine tones, each with its own frequency, enable and attenuation, normally placed on the 2.4 MHz and 5.0 MHz notch frequencies.
- Used in-system for built-in self-test: inject, filter, measure residual.
- Supports bursts of fixed length or continuous generation.

---
 rtl/dfe_pkg.sv | 37 +++
 rtl/dfe_sine_lut.sv | 58 +++++
 rtl/dfe_tone_injector.sv | 196 +++++++++++++++++++
 tb/tb_dfe_tone_injector.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dfe_pkg.sv
// Shared types and constants for the DFE two-tone stimulus path.
package dfe_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int TONE_PEAK = 16383;

  // Tone FCWs assume a 61.44 MHz sample clock and a 24-bit accumulator.
  localparam logic [23:0] FCW_2P4MHZ = 24'd655360;
  localparam logic [23:0] FCW_5P0MHZ = 24'd1365333;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tone_state_e;

  // Elaboration-time quarter-wave entry: round(TONE_PEAK*sin(pi/2*k/2^aw)).
  // Fixed-point Taylor series, 2^30 scale, so no real arithmetic is needed.
  function automatic int sine_entry(input int k, input int aw);
    longint scale;
    longint x;
    longint xx;
    longint term;
    longint acc;
    scale = 64'sd1 <<< 30;
    x     = (64'sd3373259426 * longint'(k)) >>> (aw + 1);
    xx    = (x * x) / scale;
    term  = x;
    acc   = x;
    for (int n = 1; n < 12; n++) begin
      term = -((term * xx) / scale) / longint'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return int'((acc * longint'(TONE_PEAK) + scale / 64'sd2) / scale);
  endfunction

endpackage

// File: rtl/dfe_sine_lut.sv
// Registered quarter-wave sine ROM with quadrant folding.
// Output is a signed full-wave sample, one cycle after the index, when en_i.
module dfe_sine_lut
  import dfe_pkg::*;
#(
  parameter int LUT_AW = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  input  logic [LUT_AW+1:0]          idx_i,
  output logic signed [SAMPLE_W-1:0] val_o
);

  localparam int DEPTH = (1 << LUT_AW) + 1;

  logic [13:0]                rom_s [DEPTH];
  logic [1:0]                 quad_s;
  logic [LUT_AW-1:0]          p_s;
  logic [LUT_AW:0]            addr_s;
  logic signed [SAMPLE_W-1:0] mag_s;
  logic signed [SAMPLE_W-1:0] val_d;
  logic signed [SAMPLE_W-1:0] val_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [13:0] ENTRY = 14'(sine_entry(k, LUT_AW));
    assign rom_s[k] = ENTRY;
  end

  // Odd quadrants read the table backwards; the upper half-wave is negated.
  always_comb begin
    quad_s = idx_i[LUT_AW+1 -: 2];
    p_s    = idx_i[LUT_AW-1:0];
    if (quad_s[0]) begin
      addr_s = (LUT_AW+1)'(DEPTH - 1) - {1'b0, p_s};
    end else begin
      addr_s = {1'b0, p_s};
    end
    mag_s = $signed({2'b00, rom_s[addr_s]});
    if (quad_s[1]) begin
      val_d = -mag_s;
    end else begin
      val_d = mag_s;
    end
  end

  // Sample register, advances with the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= 16'sd0;
    end else if (en_i) begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/dfe_tone_injector.sv
// Two-tone sine stimulus source with burst/continuous modes on a valid/ready port.
// Optional phase dither is enabled by defining TONE_DITHER_EN.
module dfe_tone_injector
  import dfe_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [15:0]                burst_len,
  input  logic [PHASE_W-1:0]         fcw1,
  input  logic [PHASE_W-1:0]         fcw2,
  input  logic                       tone1_en,
  input  logic                       tone2_en,
  input  logic [2:0]                 atten1,
  input  logic [2:0]                 atten2,
  output logic signed [SAMPLE_W-1:0] dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = LUT_AW + 2;

  tone_state_e                state_q, state_d;
  logic [15:0]                len_q, cnt_q;
  logic [PHASE_W-1:0]         fcw1_q, fcw2_q, acc1_q, acc2_q;
  logic                       en1_q, en2_q;
  logic [2:0]                 att1_q, att2_q;
  logic [IDX_W-1:0]           idx1_q, idx2_q, idx1_s, idx2_s;
  logic                       va_q, vl_q, dout_valid_q, done_q;
  logic signed [SAMPLE_W-1:0] lut1_s, lut2_s, t1_s, t2_s, sum_s, dout_q;
  logic                       adv_s, cont_s, issue_s, start_ok_s, last_acc_s;

  assign adv_s      = !dout_valid_q || dout_ready;
  assign cont_s     = (len_q == 16'd0);
  assign start_ok_s = start && !abort && (state_q == ST_IDLE);
  assign issue_s    = (state_q == ST_RUN) && adv_s && (cont_s || (cnt_q != len_q));
  // Final sample is the one leaving an otherwise empty pipeline while draining.
  assign last_acc_s = (state_q == ST_DRAIN) && dout_valid_q && dout_ready && !va_q && !vl_q;

`ifdef TONE_DITHER_EN
  localparam int LOW_W = PHASE_W - IDX_W;

  logic [15:0] lfsr_q;
  logic        lfsr_fb_s, carry1_s, carry2_s;

  assign lfsr_fb_s = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  // Carry out of (low phase bits + dither) without forming the unused sum bits.
  assign carry1_s  = acc1_q[LOW_W-1:0] > ~lfsr_q[LOW_W-1:0];
  assign carry2_s  = acc2_q[LOW_W-1:0] > ~lfsr_q[LOW_W-1:0];
  assign idx1_s    = acc1_q[PHASE_W-1 -: IDX_W] + IDX_W'(carry1_s);
  assign idx2_s    = acc2_q[PHASE_W-1 -: IDX_W] + IDX_W'(carry2_s);

  // Dither LFSR, reseeded per burst and stepped once per issued sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else if (start_ok_s) begin
      lfsr_q <= 16'hACE1;
    end else if (issue_s) begin
      lfsr_q <= {lfsr_fb_s, lfsr_q[15:1]};
    end
  end
`else
  assign idx1_s = acc1_q[PHASE_W-1 -: IDX_W];
  assign idx2_s = acc2_q[PHASE_W-1 -: IDX_W];
`endif

  // Next-state logic; abort overrides everything including start.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_RUN; else state_d = ST_IDLE;
        ST_RUN:   if (!cont_s && (cnt_q == len_q)) state_d = ST_DRAIN; else state_d = ST_RUN;
        ST_DRAIN: if (last_acc_s) state_d = ST_IDLE; else state_d = ST_DRAIN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Configuration latch, phase accumulators, issue counter and index stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= 16'd0;
      cnt_q  <= 16'd0;
      fcw1_q <= '0;
      fcw2_q <= '0;
      acc1_q <= '0;
      acc2_q <= '0;
      en1_q  <= 1'b0;
      en2_q  <= 1'b0;
      att1_q <= 3'd0;
      att2_q <= 3'd0;
      idx1_q <= '0;
      idx2_q <= '0;
    end else if (start_ok_s) begin
      len_q  <= burst_len;
      cnt_q  <= 16'd0;
      fcw1_q <= fcw1;
      fcw2_q <= fcw2;
      acc1_q <= '0;
      acc2_q <= '0;
      en1_q  <= tone1_en;
      en2_q  <= tone2_en;
      att1_q <= atten1;
      att2_q <= atten2;
    end else if (issue_s) begin
      acc1_q <= acc1_q + fcw1_q;
      acc2_q <= acc2_q + fcw2_q;
      cnt_q  <= cnt_q + 16'd1;
      idx1_q <= idx1_s;
      idx2_q <= idx2_s;
    end
  end

  dfe_sine_lut #(.LUT_AW(LUT_AW)) u_lut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (adv_s),
    .idx_i (idx1_q),
    .val_o (lut1_s)
  );

  dfe_sine_lut #(.LUT_AW(LUT_AW)) u_lut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (adv_s),
    .idx_i (idx2_q),
    .val_o (lut2_s)
  );

  // Per-tone attenuation and sum; two full-scale tones peak at +/-32766.
  always_comb begin
    t1_s = 16'sd0;
    t2_s = 16'sd0;
    if (en1_q) begin
      t1_s = lut1_s >>> att1_q;
    end else begin
      t1_s = 16'sd0;
    end
    if (en2_q) begin
      t2_s = lut2_s >>> att2_q;
    end else begin
      t2_s = 16'sd0;
    end
    sum_s = t1_s + t2_s;
  end

  // Valid pipeline and output register; everything freezes on a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va_q         <= 1'b0;
      vl_q         <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= 16'sd0;
      done_q       <= 1'b0;
    end else begin
      done_q <= last_acc_s && !abort;
      if (abort) begin
        va_q         <= 1'b0;
        vl_q         <= 1'b0;
        dout_valid_q <= 1'b0;
      end else if (adv_s) begin
        va_q         <= issue_s;
        vl_q         <= va_q;
        dout_valid_q <= vl_q;
        if (vl_q) begin
          dout_q <= sum_s;
        end
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dfe_tone_injector.sv
// Directed scoreboard bench for dfe_tone_injector: expected samples are queued
// from a floating-point sine model when a burst starts and popped on acceptance.
module tb_dfe_tone_injector;
  import dfe_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic [15:0]        burst_len;
  logic [23:0]        fcw1, fcw2;
  logic               tone1_en, tone2_en;
  logic [2:0]         atten1, atten2;
  logic signed [15:0] dout;
  logic               dout_valid;
  logic               dout_ready;
  logic               busy;
  logic               done;

  int total;
  int bad;
  int extra;
  int exp_q[$];
  int n_acc, n_done, done_acc, first_lat;

  dfe_tone_injector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .burst_len  (burst_len),
    .fcw1       (fcw1),
    .fcw2       (fcw2),
    .tone1_en   (tone1_en),
    .tone2_en   (tone2_en),
    .atten1     (atten1),
    .atten2     (atten2),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int tone_model(input logic [23:0] ph, input logic [2:0] att);
    logic [9:0] idx;
    int a, m, v;
    idx = ph[23:14];
    a = idx[8] ? 256 - int'(idx[7:0]) : int'(idx[7:0]);
    m = $rtoi(16383.0 * $sin(3.141592653589793 * real'(a) / 512.0) + 0.5);
    v = idx[9] ? -m : m;
    return v >>> att;
  endfunction

  function automatic int sample_model(input int k);
    logic [23:0] p1, p2;
    int s;
    p1 = 24'(longint'(k) * longint'(fcw1));
    p2 = 24'(longint'(k) * longint'(fcw2));
    s = 0;
    if (tone1_en) s += tone_model(p1, atten1);
    if (tone2_en) s += tone_model(p2, atten2);
    return s;
  endfunction

  task automatic push_model(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(sample_model(k));
  endtask

  task automatic cfg(input logic [23:0] f1, input logic [23:0] f2, input logic e1,
                     input logic e2, input logic [2:0] a1, input logic [2:0] a2,
                     input logic [15:0] len);
    fcw1 = f1; fcw2 = f2; tone1_en = e1; tone2_en = e2;
    atten1 = a1; atten2 = a2; burst_len = len;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs cycle by cycle (at posedge+1), driving ready and scoring accepted samples.
  task automatic collect(input int n_exp, input int max_cyc, input bit rnd,
                         input int abort_at, input int ign_start_at);
    int c;
    bit hold;
    int held;
    c = 0; hold = 1'b0; held = 0;
    n_acc = 0; n_done = 0; done_acc = -1; first_lat = -1;
    while (c < max_cyc) begin
      if (dout_valid && first_lat < 0) first_lat = c;
      if (done) begin n_done++; done_acc = n_acc; end
      if (hold) begin
        check("stall_valid", int'(dout_valid), 1);
        check("stall_data", int'(dout), held);
      end
      if (n_acc >= n_exp && !busy) break;
      dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (c == ign_start_at);
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) extra++;
        else check("sample", int'(dout), exp_q.pop_front());
        n_acc++;
        if (n_acc == abort_at) abort = 1'b1;
      end
      hold = dout_valid && !dout_ready;
      held = int'(dout);
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      c++;
    end
  endtask

  task automatic run_basic(input string tag);
    int ref_seq[8];
    ref_seq = '{0, 16383, 0, -16383, 0, 16383, 0, -16383};
    cfg(24'h400000, 24'h000000, 1'b1, 1'b0, 3'd0, 3'd0, 16'd8);
    foreach (ref_seq[i]) exp_q.push_back(ref_seq[i]);
    do_start();
    collect(8, 100, 1'b0, -1, -1);
    check({tag, "_count"}, n_acc, 8);
    check({tag, "_latency"}, first_lat, 3);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_done_at"}, done_acc, 8);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    total = 0; bad = 0; extra = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; dout_ready = 1'b1;
    cfg(24'h000000, 24'h000000, 1'b0, 1'b0, 3'd0, 3'd0, 16'd0);
    #12;
    check("rst_dout", int'(dout), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single tone burst, full ready.
    run_basic("t1");

    // Both tones full scale, then tone 1 attenuated by one.
    cfg(24'h400000, 24'h400000, 1'b1, 1'b1, 3'd0, 3'd0, 16'd8);
    push_model(8);
    do_start();
    collect(8, 100, 1'b0, -1, -1);
    check("dual_count", n_acc, 8);
    check("dual_done", n_done, 1);

    cfg(24'h400000, 24'h400000, 1'b1, 1'b1, 3'd1, 3'd0, 16'd8);
    push_model(8);
    do_start();
    collect(8, 100, 1'b0, -1, -1);
    check("att_count", n_acc, 8);

    // Random backpressure on the basic burst and on a mixed-frequency burst.
    cfg(24'h400000, 24'h000000, 1'b1, 1'b0, 3'd0, 3'd0, 16'd8);
    push_model(8);
    do_start();
    collect(8, 200, 1'b1, -1, -1);
    check("bp_count", n_acc, 8);
    check("bp_done", n_done, 1);
    check("bp_left", exp_q.size(), 0);

    cfg(FCW_2P4MHZ, FCW_5P0MHZ, 1'b1, 1'b1, 3'd1, 3'd2, 16'd40);
    push_model(40);
    do_start();
    collect(40, 400, 1'b1, -1, -1);
    check("mix_count", n_acc, 40);
    check("mix_done", n_done, 1);

    // Abort on the 3rd accepted sample, then replay from phase zero.
    cfg(24'h400000, 24'h000000, 1'b1, 1'b0, 3'd0, 3'd0, 16'd8);
    push_model(8);
    do_start();
    collect(3, 100, 1'b0, 3, -1);
    check("abort_valid", int'(dout_valid), 0);
    check("abort_busy", int'(busy), 0);
    exp_q.delete();
    collect(1, 6, 1'b0, -1, -1);
    check("abort_no_done", n_done, 0);
    check("abort_no_sample", n_acc, 0);
    run_basic("replay");

    // Continuous mode; config changes and a second start must be ignored.
    cfg(FCW_2P4MHZ, FCW_5P0MHZ, 1'b1, 1'b1, 3'd0, 3'd1, 16'd0);
    push_model(1100);
    do_start();
    fcw1 = 24'h123456;
    atten2 = 3'd4;
    collect(1000000, 1000, 1'b0, -1, 500);
    check("cont_count", n_acc, 997);
    check("cont_no_done", n_done, 0);
    check("cont_busy", int'(busy), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("cont_abort_busy", int'(busy), 0);
    check("cont_abort_valid", int'(dout_valid), 0);
    exp_q.delete();

    // Asynchronous reset in the middle of a burst.
    cfg(24'h400000, 24'h000000, 1'b1, 1'b0, 3'd0, 3'd0, 16'd8);
    push_model(8);
    do_start();
    collect(8, 5, 1'b0, -1, -1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_dout", int'(dout), 0);
    check("mid_rst_valid", int'(dout_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    exp_q.delete();
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_basic("post_rst");

    check("no_extra_samples", extra, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
